// File: rtl/rc5_pkg.sv
// -----------------------------------------------------------------------------
// rc5_pkg
//
// Shared definitions for the RC5 encryption datapath:
//   - rc5_state_e  : sequencer states of the round controller
//   - P32 / Q32    : RC5 magic constants, also used by key expansion
//   - rot_bits_f   : rotate-amount width for a W-bit word
//   - cnt_bits_f   : round-counter width able to hold 0..R
// -----------------------------------------------------------------------------
package rc5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE_A  = 3'd1,
        ST_PRE_B  = 3'd2,
        ST_HALF_A = 3'd3,
        ST_HALF_B = 3'd4,
        ST_DONE   = 3'd5
    } rc5_state_e;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    // Width of the rotate amount: only the low log2(W) bits of a word matter.
    function automatic int rot_bits_f(input int w);
        return $clog2(w);
    endfunction

    // Width of a counter that must reach R itself (not just R-1).
    function automatic int cnt_bits_f(input int r);
        return $clog2(r + 1);
    endfunction

endpackage

// File: rtl/rc5_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// rc5_round_ctrl_if
//
// Bundles the plaintext handshake, the S-table read port and the ciphertext
// handshake of the RC5 round controller.
//   iValid/oReady/iA/iB          : plaintext pair in
//   oS_address/iS_sub_i          : S-table read (combinational RAM read)
//   oValid/iReady/oA/oB_cipher   : ciphertext pair out
//   oBusy                        : controller is not idle
// Modports:
//   slave  - the round controller
//   master - front end / S-table owner / downstream sink
// -----------------------------------------------------------------------------
interface rc5_round_ctrl_if #(
    parameter int W = 32
);
    logic         iValid;
    logic         oReady;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic [W-1:0] oS_address;
    logic [W-1:0] iS_sub_i;
    logic         oValid;
    logic         iReady;
    logic [W-1:0] oA_cipher;
    logic [W-1:0] oB_cipher;
    logic         oBusy;

    modport slave (
        input  iValid, iA, iB, iS_sub_i, iReady,
        output oReady, oS_address, oValid, oA_cipher, oB_cipher, oBusy
    );

    modport master (
        output iValid, iA, iB, iS_sub_i, iReady,
        input  oReady, oS_address, oValid, oA_cipher, oB_cipher, oBusy
    );
endinterface

// File: rtl/rc5_rotl.sv
// -----------------------------------------------------------------------------
// rc5_rotl
//
// Combinational W-bit left rotator.
//   data_i   : word to rotate
//   amt_i    : rotate amount (low log2(W) bits of the rotator word)
//   result_o : data_i rotated left by amt_i; amount 0 is identity
// -----------------------------------------------------------------------------
module rc5_rotl
    import rc5_pkg::*;
#(
    parameter int W        = 32,
    parameter int ROT_BITS = rot_bits_f(W)
) (
    input  logic [W-1:0]        data_i,
    input  logic [ROT_BITS-1:0] amt_i,
    output logic [W-1:0]        result_o
);

    logic [2*W-1:0] doubled;

    // Shifting two back-to-back copies left leaves the rotated word in the
    // upper half, which avoids a variable right shift by (W - amt).
    always_comb begin
        doubled  = {data_i, data_i} << amt_i;
        result_o = doubled[2*W-1:W];
    end

endmodule

// File: rtl/rc5_round_ctrl.sv
// -----------------------------------------------------------------------------
// rc5_round_ctrl
//
// RC5 encryption sequencer. Accepts a plaintext pair (A,B), walks the S-table
// one half-round per cycle (pre-whitening, then R rounds of XOR / data-
// dependent rotate / add) and presents the ciphertext pair until the
// downstream sink accepts it.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : rc5_round_ctrl_if.slave
//            iValid/oReady/iA/iB        plaintext handshake (accept in IDLE)
//            oS_address/iS_sub_i        S-table index (registered) and data
//            oValid/iReady/oA/oB_cipher ciphertext handshake (held in DONE)
//            oBusy                      high in every state except IDLE
//
// Latency: accept at edge 0 -> oValid high after edge 2R+2.
// -----------------------------------------------------------------------------
module rc5_round_ctrl
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic             clk,
    input  logic             rst,
    rc5_round_ctrl_if.slave  bus
);

    localparam int ROT_BITS = rot_bits_f(W);
    localparam int CNT_BITS = cnt_bits_f(R);

    localparam logic [CNT_BITS-1:0] LAST_ROUND  = CNT_BITS'(R);
    localparam logic [CNT_BITS-1:0] FIRST_ROUND = CNT_BITS'(1);
    localparam logic [W-1:0]        ADDR_MAX    = W'(2 * R + 1);

    rc5_state_e          state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        addr_q, addr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                last_round;
    logic [ROT_BITS-1:0] rot_amt;
    logic [W-1:0]        rot_out;

    assign last_round = (cnt_q == LAST_ROUND);

    // -------------------------------------------------------------------------
    // Shared rotator. Both half-rounds rotate A^B (XOR commutes); only the
    // amount differs: B's low bits in HALF_A, the freshly updated A's in HALF_B.
    // -------------------------------------------------------------------------
    always_comb begin
        rot_amt = (state_q == ST_HALF_B) ? a_q[ROT_BITS-1:0] : b_q[ROT_BITS-1:0];
    end

    rc5_rotl #(
        .W        (W),
        .ROT_BITS (ROT_BITS)
    ) u_rotl (
        .data_i   (a_q ^ b_q),
        .amt_i    (rot_amt),
        .result_o (rot_out)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned, so no
    // latch is inferred for states that simply hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.iValid) state_d = ST_PRE_A;
            ST_PRE_A:  state_d = ST_PRE_B;
            ST_PRE_B:  state_d = ST_HALF_A;
            ST_HALF_A: state_d = ST_HALF_B;
            ST_HALF_B: state_d = last_round ? ST_DONE : ST_HALF_A;
            ST_DONE:   if (bus.iReady) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (all decoded from registered state or registers)
    // -------------------------------------------------------------------------
    always_comb begin
        bus.oReady     = (state_q == ST_IDLE);
        bus.oBusy      = (state_q != ST_IDLE);
        bus.oValid     = (state_q == ST_DONE);
        bus.oS_address = addr_q;
        bus.oA_cipher  = a_q;
        bus.oB_cipher  = b_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next-state. The address register always runs one step ahead of
    // the half-round being computed: it already points at S[2i] when HALF_A
    // of round i starts, so each active state simply advances it by one.
    // -------------------------------------------------------------------------
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iValid) begin
                    a_d    = bus.iA;
                    b_d    = bus.iB;
                    addr_d = '0;
                end
            end
            ST_PRE_A: begin
                a_d    = a_q + bus.iS_sub_i;
                addr_d = addr_q + W'(1);
            end
            ST_PRE_B: begin
                b_d    = b_q + bus.iS_sub_i;
                addr_d = addr_q + W'(1);
                cnt_d  = FIRST_ROUND;
            end
            ST_HALF_A: begin
                a_d    = rot_out + bus.iS_sub_i;
                addr_d = addr_q + W'(1);
            end
            ST_HALF_B: begin
                b_d = rot_out + bus.iS_sub_i;
                // The final half-round leaves the address at 2R+1.
                if (!last_round) begin
                    cnt_d  = cnt_q + CNT_BITS'(1);
                    addr_d = addr_q + W'(1);
                end
            end
            default: begin
                // DONE: hold the ciphertext and the last address.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    addr_in_range_a: assert property (@(posedge clk) disable iff (!rst)
        addr_q <= ADDR_MAX);

    round_in_range_a: assert property (@(posedge clk) disable iff (!rst)
        cnt_q <= LAST_ROUND);

    valid_not_ready_a: assert property (@(posedge clk) disable iff (!rst)
        !(bus.oValid && bus.oReady));

endmodule

// File: tb/tb_rc5_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rc5_round_ctrl
//
// Bench for rc5_round_ctrl: one R=12 instance and one R=1 instance, each with
// an S-table array answering the combinational read. Expected ciphertext comes
// from a plain-arithmetic RC5 model; the zero-key S table is built by an RC5
// key-expansion model.
// -----------------------------------------------------------------------------
module tb_rc5_round_ctrl;
    import rc5_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rc5_round_ctrl_if #(.W(32)) bus12 ();
    rc5_round_ctrl_if #(.W(32)) bus1 ();

    rc5_round_ctrl #(.W(32), .R(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    rc5_round_ctrl #(.W(32), .R(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [31:0] s12 [26];
    logic [31:0] s1  [4];

    always_comb begin
        bus12.iS_sub_i = 32'h0;
        if (bus12.oS_address < 32'd26) bus12.iS_sub_i = s12[bus12.oS_address[4:0]];
    end

    always_comb begin
        bus1.iS_sub_i = 32'h0;
        if (bus1.oS_address < 32'd4) bus1.iS_sub_i = s1[bus1.oS_address[1:0]];
    end

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic void ref_enc(input logic [31:0] a_in, input logic [31:0] b_in,
                                    input int rounds, input logic [31:0] s [26],
                                    output logic [31:0] a_out, output logic [31:0] b_out);
        logic [31:0] a, b;
        a = a_in + s[0];
        b = b_in + s[1];
        for (int i = 1; i <= rounds; i++) begin
            a = rotl32(a ^ b, int'(b & 32'd31)) + s[2*i];
            b = rotl32(b ^ a, int'(a & 32'd31)) + s[2*i+1];
        end
        a_out = a;
        b_out = b;
    endfunction

    // RC5-32/12/16 key expansion with an all-zero 16-byte key.
    task automatic load_zero_key_schedule();
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        s12[0] = P32;
        for (int k = 1; k < 26; k++) s12[k] = s12[k-1] + Q32;
        for (int k = 0; k < 4; k++) l[k] = 32'h0;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a      = rotl32(s12[i] + a + b, 3);
            s12[i] = a;
            b      = rotl32(l[j] + a + b, int'((a + b) & 32'd31));
            l[j]   = b;
            i      = (i + 1) % 26;
            j      = (j + 1) % 4;
        end
    endtask

    task automatic randomize_s12();
        for (int k = 0; k < 26; k++) s12[k] = $urandom;
    endtask

    // Drives one pair into the R=12 instance from an idle negedge and waits
    // (bounded) for oValid. lat counts edges after the accept edge; addr_ok
    // records whether the address equalled that edge count on every busy cycle.
    task automatic run12(input logic [31:0] a, input logic [31:0] b, input bit release_out,
                         output logic [31:0] ra, output logic [31:0] rb,
                         output int lat, output bit addr_ok);
        int k;
        bus12.iA     = a;
        bus12.iB     = b;
        bus12.iValid = 1'b1;
        @(negedge clk);
        bus12.iValid = 1'b0;
        k       = 0;
        addr_ok = 1'b1;
        while (!bus12.oValid && k < 200) begin
            if (bus12.oS_address !== 32'(k)) addr_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        lat = k;
        ra  = bus12.oA_cipher;
        rb  = bus12.oB_cipher;
        if (release_out) begin
            bus12.iReady = 1'b1;
            @(negedge clk);
            bus12.iReady = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst          = 1'b0;
        bus12.iValid = 1'b0; bus12.iReady = 1'b0; bus12.iA = '0; bus12.iB = '0;
        bus1.iValid  = 1'b0; bus1.iReady  = 1'b0; bus1.iA  = '0; bus1.iB  = '0;
        for (int k = 0; k < 26; k++) s12[k] = '0;
        for (int k = 0; k < 4; k++)  s1[k]  = '0;
        repeat (3) @(negedge clk);
        total++; if (bus12.oReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus12.oReady); end
        total++; if (bus12.oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus12.oValid); end
        total++; if (bus12.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus12.oBusy); end
        total++; if (bus12.oS_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus12.oS_address); end
        total++; if ({bus12.oA_cipher, bus12.oB_cipher} !== 64'h0) begin bad++; $display("FAIL reset_ab got=%h_%h exp=0_0", bus12.oA_cipher, bus12.oB_cipher); end
        total++; if ({bus1.oReady, bus1.oBusy, bus1.oValid} !== 3'b100) begin bad++; $display("FAIL reset_r1 got=%b exp=100", {bus1.oReady, bus1.oBusy, bus1.oValid}); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({bus12.oReady, bus12.oBusy} !== 2'b10) begin bad++; $display("FAIL idle_after_reset got=%b exp=10", {bus12.oReady, bus12.oBusy}); end
    endtask

    task automatic test_r1();
        logic [31:0] tab [26];
        logic [31:0] ea, eb, a, b;
        int  k;
        bit  addr_ok;
        for (int it = 0; it < 5; it++) begin
            // First pass is the fixed A=1, B=0, S=0 vector; the rest are random.
            a = (it == 0) ? 32'h1 : $urandom;
            b = (it == 0) ? 32'h0 : $urandom;
            for (int x = 0; x < 4; x++)  s1[x]  = (it == 0) ? 32'h0 : $urandom;
            for (int x = 0; x < 26; x++) tab[x] = (x < 4) ? s1[x] : 32'h0;
            ref_enc(a, b, 1, tab, ea, eb);
            bus1.iA = a; bus1.iB = b; bus1.iValid = 1'b1;
            @(negedge clk);
            bus1.iValid = 1'b0;
            k = 0; addr_ok = 1'b1;
            while (!bus1.oValid && k < 50) begin
                if (bus1.oS_address !== 32'(k)) addr_ok = 1'b0;
                @(negedge clk);
                k++;
            end
            total++; if (k !== 4) begin bad++; $display("FAIL r1_latency it=%0d got=%0d exp=4", it, k); end
            total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL r1_addr_seq it=%0d got=bad_step exp=0..3", it); end
            total++; if ({bus1.oA_cipher, bus1.oB_cipher} !== {ea, eb}) begin bad++; $display("FAIL r1_cipher it=%0d got=%h_%h exp=%h_%h", it, bus1.oA_cipher, bus1.oB_cipher, ea, eb); end
            if (it == 0) begin
                total++; if ({bus1.oA_cipher, bus1.oB_cipher} !== {32'h1, 32'h2}) begin bad++; $display("FAIL r1_vector got=%h_%h exp=1_2", bus1.oA_cipher, bus1.oB_cipher); end
            end
            bus1.iReady = 1'b1;
            @(negedge clk);
            bus1.iReady = 1'b0;
        end
    endtask

    task automatic test_zero_r12();
        logic [31:0] ra, rb;
        int lat;
        bit addr_ok;
        for (int k = 0; k < 26; k++) s12[k] = '0;
        run12(32'h0, 32'h0, 1'b1, ra, rb, lat, addr_ok);
        total++; if (lat !== 26) begin bad++; $display("FAIL zero_latency got=%0d exp=26", lat); end
        total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL zero_addr_seq got=bad_step exp=0..25"); end
        total++; if ({ra, rb} !== 64'h0) begin bad++; $display("FAIL zero_cipher got=%h_%h exp=0_0", ra, rb); end
    endtask

    task automatic test_known_vector();
        logic [31:0] ra, rb, ea, eb;
        int lat;
        bit addr_ok;
        load_zero_key_schedule();
        ref_enc(32'h0, 32'h0, 12, s12, ea, eb);
        run12(32'h0, 32'h0, 1'b1, ra, rb, lat, addr_ok);
        total++; if ({ra, rb} !== {32'hEEDBA521, 32'h6D8F4B15}) begin bad++; $display("FAIL kv_cipher got=%h_%h exp=eedba521_6d8f4b15", ra, rb); end
        total++; if ({ra, rb} !== {ea, eb}) begin bad++; $display("FAIL kv_model got=%h_%h exp=%h_%h", ra, rb, ea, eb); end
        total++; if (lat !== 26) begin bad++; $display("FAIL kv_latency got=%0d exp=26", lat); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, ra, rb, ea, eb;
        int lat;
        bit addr_ok;
        for (int it = 0; it < 8; it++) begin
            randomize_s12();
            a = $urandom; b = $urandom;
            ref_enc(a, b, 12, s12, ea, eb);
            run12(a, b, 1'b1, ra, rb, lat, addr_ok);
            total++; if ({ra, rb} !== {ea, eb}) begin bad++; $display("FAIL rand_cipher it=%0d got=%h_%h exp=%h_%h", it, ra, rb, ea, eb); end
            total++; if (lat !== 26 || addr_ok !== 1'b1) begin bad++; $display("FAIL rand_timing it=%0d got=lat%0d_addr%0b exp=lat26_addr1", it, lat, addr_ok); end
        end
    endtask

    task automatic test_done_hold();
        logic [31:0] a, b, ra, rb, ea, eb;
        int lat;
        bit addr_ok;
        randomize_s12();
        a = $urandom; b = $urandom;
        ref_enc(a, b, 12, s12, ea, eb);
        run12(a, b, 1'b0, ra, rb, lat, addr_ok);
        total++; if ({ra, rb} !== {ea, eb}) begin bad++; $display("FAIL hold_cipher got=%h_%h exp=%h_%h", ra, rb, ea, eb); end
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                bus12.iValid = 1'b1; bus12.iA = $urandom; bus12.iB = $urandom;
            end else begin
                bus12.iValid = 1'b0;
            end
            @(negedge clk);
            total++;
            if ({bus12.oValid, bus12.oReady, bus12.oA_cipher, bus12.oB_cipher} !== {1'b1, 1'b0, ea, eb}) begin
                bad++;
                $display("FAIL hold_stable c=%0d got=v%b_r%b_%h_%h exp=v1_r0_%h_%h", c, bus12.oValid, bus12.oReady, bus12.oA_cipher, bus12.oB_cipher, ea, eb);
            end
        end
        bus12.iValid = 1'b0;
        bus12.iReady = 1'b1;
        @(negedge clk);
        bus12.iReady = 1'b0;
        total++; if ({bus12.oValid, bus12.oReady, bus12.oBusy} !== 3'b010) begin bad++; $display("FAIL hold_release got=%b exp=010", {bus12.oValid, bus12.oReady, bus12.oBusy}); end
        @(negedge clk);
        total++; if (bus12.oBusy !== 1'b0) begin bad++; $display("FAIL hold_ignored_pulse got=%b exp=0", bus12.oBusy); end
    endtask

    task automatic test_abort_reset();
        logic [31:0] ra, rb;
        int k, lat;
        bit addr_ok;
        randomize_s12();
        bus12.iA = $urandom; bus12.iB = $urandom; bus12.iValid = 1'b1;
        @(negedge clk);
        bus12.iValid = 1'b0;
        // Address 11 marks HALF_B of round 5.
        k = 0;
        while (bus12.oS_address !== 32'd11 && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++; if (k !== 11) begin bad++; $display("FAIL abort_reach_r5 got=%0d exp=11", k); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus12.oValid, bus12.oBusy, bus12.oReady, bus12.oS_address} !== {3'b001, 32'h0}) begin
            bad++;
            $display("FAIL abort_state got=v%b_b%b_r%b_a%h exp=v0_b0_r1_a0", bus12.oValid, bus12.oBusy, bus12.oReady, bus12.oS_address);
        end
        rst = 1'b1;
        @(negedge clk);
        load_zero_key_schedule();
        run12(32'h0, 32'h0, 1'b1, ra, rb, lat, addr_ok);
        total++; if ({ra, rb} !== {32'hEEDBA521, 32'h6D8F4B15}) begin bad++; $display("FAIL abort_recover got=%h_%h exp=eedba521_6d8f4b15", ra, rb); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, e1a, e1b, e2a, e2b;
        int k;
        randomize_s12();
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        ref_enc(a1, b1, 12, s12, e1a, e1b);
        ref_enc(a2, b2, 12, s12, e2a, e2b);
        bus12.iReady = 1'b1;
        bus12.iA = a1; bus12.iB = b1; bus12.iValid = 1'b1;
        @(negedge clk);
        bus12.iA = a2; bus12.iB = b2;
        k = 0;
        while (!bus12.oValid && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++; if (k !== 26) begin bad++; $display("FAIL b2b_latency1 got=%0d exp=26", k); end
        total++; if ({bus12.oA_cipher, bus12.oB_cipher} !== {e1a, e1b}) begin bad++; $display("FAIL b2b_cipher1 got=%h_%h exp=%h_%h", bus12.oA_cipher, bus12.oB_cipher, e1a, e1b); end
        @(negedge clk);
        total++; if ({bus12.oReady, bus12.oBusy, bus12.oValid} !== 3'b100) begin bad++; $display("FAIL b2b_idle_gap got=%b exp=100", {bus12.oReady, bus12.oBusy, bus12.oValid}); end
        @(negedge clk);
        total++; if ({bus12.oBusy, bus12.oS_address} !== {1'b1, 32'h0}) begin bad++; $display("FAIL b2b_accept2 got=b%b_a%h exp=b1_a0", bus12.oBusy, bus12.oS_address); end
        bus12.iValid = 1'b0;
        k = 0;
        while (!bus12.oValid && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++; if (k !== 26) begin bad++; $display("FAIL b2b_latency2 got=%0d exp=26", k); end
        total++; if ({bus12.oA_cipher, bus12.oB_cipher} !== {e2a, e2b}) begin bad++; $display("FAIL b2b_cipher2 got=%h_%h exp=%h_%h", bus12.oA_cipher, bus12.oB_cipher, e2a, e2b); end
        @(negedge clk);
        bus12.iReady = 1'b0;
        total++; if (bus12.oBusy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle got=%b exp=0", bus12.oBusy); end
    endtask

    initial begin
        test_reset();
        test_r1();
        test_zero_r12();
        test_known_vector();
        test_random();
        test_done_hold();
        test_abort_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
